// File: rtl/func_gen_seq_ctrl.sv
// Function-generator sequence controller: channel config, shared sample addressing, generate enables.
// Optional one-shot pass mode (HOLD state, done_o pulse) is built only when FGEN_ONESHOT_EN is defined.
module func_gen_seq_ctrl #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_low_i,
    input  logic              enh_conf_i,
    input  logic [CH_W-1:0]   ch_sel_i,
    input  logic [NUM_CH-1:0] ch_mask_i,
    input  logic              step_i,
    input  logic              oneshot_i,
    output logic [NUM_CH-1:0] enh_config_o,
    output logic [NUM_CH-1:0] enh_gen_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              clrh_addr_o,
    output logic              done_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StConfi, StGen, StHold} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic              oneshot_q, oneshot_d;
    logic [NUM_CH-1:0] config_q, config_d;
    logic [NUM_CH-1:0] gen_q, gen_d;
    logic              clr_q, clr_d;
    logic              done_q, done_d;
    logic              at_last;
    logic              pass_end;

    assign at_last = (addr_q == LAST_ADDR);

`ifdef FGEN_ONESHOT_EN
    assign pass_end = oneshot_q & step_i & at_last;
`else
    logic unused_oneshot;
    assign unused_oneshot = oneshot_q;
    assign pass_end       = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        mask_d    = mask_q;
        oneshot_d = oneshot_q;
        addr_d    = addr_q;

        if (enh_conf_i) begin
            state_d = StConfi;
        end else if (en_low_i) begin
            state_d = StIdle;
        end else if (state_q == StHold || (state_q == StGen && pass_end)) begin
            state_d = StHold;
        end else begin
            state_d = StGen;
        end

        if (state_d == StConfi && state_q != StConfi) begin
            ch_d = (32'(ch_sel_i) < NUM_CH) ? ch_sel_i : '0;
        end
        if (state_d == StGen && state_q != StGen) begin
            mask_d    = ch_mask_i;
            oneshot_d = oneshot_i;
        end

        // Any state change restarts the address, except that a finished pass parks on the last sample.
        if (state_d != state_q) begin
            addr_d = (state_d == StHold) ? LAST_ADDR : '0;
        end else if ((state_q == StConfi || state_q == StGen) && step_i) begin
            addr_d = at_last ? '0 : addr_q + 1'b1;
        end

        config_d = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            config_d[i] = (state_d == StConfi) && (ch_d == CH_W'(i));
        end
        gen_d  = (state_d == StGen) ? mask_d : '0;
        clr_d  = (state_d == StIdle) || (state_d == StConfi);
        done_d = (state_q == StGen) && (state_d == StHold);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            ch_q      <= '0;
            mask_q    <= '0;
            oneshot_q <= 1'b0;
            config_q  <= '0;
            gen_q     <= '0;
            clr_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            ch_q      <= ch_d;
            mask_q    <= mask_d;
            oneshot_q <= oneshot_d;
            config_q  <= config_d;
            gen_q     <= gen_d;
            clr_q     <= clr_d;
            done_q    <= done_d;
        end
    end

    assign enh_config_o = config_q;
    assign enh_gen_o    = gen_q;
    assign addr_o       = addr_q;
    assign clrh_addr_o  = clr_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_func_gen_seq_ctrl.sv
// Self-checking bench for func_gen_seq_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model of the controller's rules.
module tb_func_gen_seq_ctrl;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CH_W   = 2;
    localparam int unsigned VEC_W  = ADDR_W + 2 * NUM_CH + 2;
`ifdef FGEN_ONESHOT_EN
    localparam bit OS_EN = 1'b1;
`else
    localparam bit OS_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en_low_i = 1'b1;
    logic              enh_conf_i = 1'b0;
    logic [CH_W-1:0]   ch_sel_i = '0;
    logic [NUM_CH-1:0] ch_mask_i = '0;
    logic              step_i = 1'b0;
    logic              oneshot_i = 1'b0;
    logic [NUM_CH-1:0] enh_config_o;
    logic [NUM_CH-1:0] enh_gen_o;
    logic [ADDR_W-1:0] addr_o;
    logic              clrh_addr_o;
    logic              done_o;

    int n_cmp = 0;
    int n_fail = 0;

    func_gen_seq_ctrl #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_low_i     (en_low_i),
        .enh_conf_i   (enh_conf_i),
        .ch_sel_i     (ch_sel_i),
        .ch_mask_i    (ch_mask_i),
        .step_i       (step_i),
        .oneshot_i    (oneshot_i),
        .enh_config_o (enh_config_o),
        .enh_gen_o    (enh_gen_o),
        .addr_o       (addr_o),
        .clrh_addr_o  (clrh_addr_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 configuring, 2 generating, 3 finished pass
    int                m_mode;
    int                m_addr;
    int                m_ch;
    logic [NUM_CH-1:0] m_mask;
    bit                m_os;
    logic [VEC_W-1:0]  exp_vec;
    logic [VEC_W-1:0]  act_vec;

    assign act_vec = {addr_o, enh_config_o, enh_gen_o, clrh_addr_o, done_o};

    task automatic model_reset();
        m_mode  = 0;
        m_addr  = 0;
        m_ch    = 0;
        m_mask  = '0;
        m_os    = 1'b0;
        exp_vec = '0;
    endtask

    task automatic model_clock();
        int  nxt;
        bit  done;
        logic [NUM_CH-1:0] cfg;
        done = 1'b0;
        if (enh_conf_i) nxt = 1;
        else if (en_low_i) nxt = 0;
        else if (m_mode == 3) nxt = 3;
        else if (m_mode == 2 && OS_EN && m_os && step_i && m_addr == DEPTH - 1) nxt = 3;
        else nxt = 2;
        if (nxt != m_mode) begin
            if (nxt == 1) m_ch = (int'(ch_sel_i) < NUM_CH) ? int'(ch_sel_i) : 0;
            if (nxt == 2) begin
                m_mask = ch_mask_i;
                m_os   = oneshot_i;
            end
            if (nxt == 3) begin
                m_addr = DEPTH - 1;
                done   = 1'b1;
            end else begin
                m_addr = 0;
            end
        end else if ((nxt == 1 || nxt == 2) && step_i) begin
            m_addr = (m_addr + 1) % DEPTH;
        end
        m_mode = nxt;
        cfg = (m_mode == 1) ? NUM_CH'(1 << m_ch) : '0;
        exp_vec = {ADDR_W'(m_addr), cfg, (m_mode == 2) ? m_mask : {NUM_CH{1'b0}},
                   (m_mode <= 1), done};
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #12;
        n_cmp++;
        if (act_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL reset_state actual=%h required=%h", act_vec, exp_vec);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        en_low_i = 1'b1;
        tick();
        n_cmp++;
        if (act_vec !== exp_vec || clrh_addr_o !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_after_reset actual=%h required=%h", act_vec, exp_vec);
        end
    endtask

    task automatic test_config();
        enh_conf_i = 1'b1;
        ch_sel_i   = 2'd2;
        tick();
        for (int i = 0; i < 3; i++) begin
            step_i = 1'b1;
            tick();
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL config_step%0d actual=%h required=%h", i, act_vec, exp_vec);
            end
        end
        step_i   = 1'b0;
        ch_sel_i = 2'd1;
        tick();
        n_cmp++;
        if (enh_config_o !== 4'b0100 || addr_o !== 8'd3) begin
            n_fail++;
            $display("FAIL config_hold_sel actual=%b/%0d required=0100/3", enh_config_o, addr_o);
        end
        step_i = 1'b1;
        tick();
        n_cmp++;
        if (act_vec !== exp_vec || addr_o !== 8'd0) begin
            n_fail++;
            $display("FAIL config_wrap actual=%h required=%h", act_vec, exp_vec);
        end
        step_i = 1'b0;
    endtask

    task automatic test_continuous();
        enh_conf_i = 1'b0;
        en_low_i   = 1'b0;
        ch_mask_i  = 4'b1010;
        oneshot_i  = 1'b0;
        tick();
        n_cmp++;
        if (act_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL gen_entry actual=%h required=%h", act_vec, exp_vec);
        end
        step_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (act_vec !== exp_vec || enh_gen_o !== 4'b1010) begin
                n_fail++;
                $display("FAIL gen_cont_step%0d actual=%h required=%h", i, act_vec, exp_vec);
            end
        end
        step_i = 1'b0;
    endtask

    task automatic test_oneshot();
        en_low_i = 1'b1;
        tick();
        en_low_i  = 1'b0;
        oneshot_i = 1'b1;
        ch_mask_i = 4'b0111;
        tick();
        step_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL oneshot_step%0d actual=%h required=%h", i, act_vec, exp_vec);
            end
        end
        en_low_i = 1'b1;
        tick();
        n_cmp++;
        if (act_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL oneshot_exit actual=%h required=%h", act_vec, exp_vec);
        end
        step_i = 1'b0;
    endtask

    task automatic test_conf_preempt();
        en_low_i  = 1'b0;
        oneshot_i = 1'b0;
        ch_mask_i = 4'b1111;
        tick();
        step_i = 1'b1;
        tick();
        tick();
        enh_conf_i = 1'b1;
        ch_sel_i   = 2'd3;
        tick();
        n_cmp++;
        if (act_vec !== exp_vec || addr_o !== 8'd0 || enh_gen_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL conf_preempt actual=%h required=%h", act_vec, exp_vec);
        end
        enh_conf_i = 1'b0;
        step_i     = 1'b0;
    endtask

    task automatic test_zero_mask();
        ch_mask_i = 4'b0000;
        en_low_i  = 1'b0;
        step_i    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL zero_mask%0d actual=%h required=%h", i, act_vec, exp_vec);
            end
        end
        step_i = 1'b0;
    endtask

    task automatic test_async_reset();
        en_low_i  = 1'b1;
        tick();
        en_low_i  = 1'b0;
        oneshot_i = 1'b1;
        ch_mask_i = 4'b0101;
        tick();
        step_i = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (act_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL async_reset actual=%h required=%h", act_vec, exp_vec);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (act_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL reset_no_done actual=%h required=%h", act_vec, exp_vec);
        end
        rst_n  = 1'b1;
        step_i = 1'b1;
        tick();
        n_cmp++;
        if (act_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL after_release actual=%h required=%h", act_vec, exp_vec);
        end
        step_i = 1'b0;
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            enh_conf_i = ($urandom_range(0, 99) < 8);
            en_low_i   = ($urandom_range(0, 99) < 8);
            ch_sel_i   = CH_W'($urandom);
            ch_mask_i  = NUM_CH'($urandom);
            step_i     = ($urandom_range(0, 99) < 70);
            oneshot_i  = $urandom_range(0, 1);
            tick();
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random%0d actual=%h required=%h", i, act_vec, exp_vec);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_config();
        test_continuous();
        test_oneshot();
        test_conf_preempt();
        test_zero_mask();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
